// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings
// (PLL lock input, relock request, PLL/domain resets and status).
interface pll_lock_sequencer_if #(
  parameter int unsigned N_DOM = 3,
  parameter int unsigned CNT_W = 8
);
  logic             pll_locked;
  logic             force_relock;
  logic             pll_rst;
  logic [N_DOM-1:0] domain_rst_n;
  logic             ready;
  logic [CNT_W-1:0] lost_cnt;
  logic [2:0]       state;

  modport master (
    input  pll_locked, force_relock,
    output pll_rst, domain_rst_n, ready, lost_cnt, state
  );

  modport slave (
    output pll_locked, force_relock,
    input  pll_rst, domain_rst_n, ready, lost_cnt, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the synchronised lock,
// releases downstream domain resets in order and re-locks on loss or request.
module pll_lock_sequencer #(
  parameter int unsigned N_DOM            = 3,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned PLL_RST_CYCLES   = 16,
  parameter int unsigned LOCK_QUAL_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned STAGGER_CYCLES   = 8,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // One counter is shared by every state, so it is sized for the longest phase.
  localparam int unsigned REL_LAST = (N_DOM - 1) * STAGGER_CYCLES;
  localparam int unsigned M_A  = (PLL_RST_CYCLES > LOCK_QUAL_CYCLES) ? PLL_RST_CYCLES : LOCK_QUAL_CYCLES;
  localparam int unsigned M_B  = (M_A > LOCK_TIMEOUT) ? M_A : LOCK_TIMEOUT;
  localparam int unsigned CMAX = (M_B > REL_LAST + 1) ? M_B : REL_LAST + 1;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] PRC_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] QUAL_LAST = CW'(LOCK_QUAL_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] REL_LASTC = CW'(REL_LAST);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0]       dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
  logic                   lost_ev, relock;

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      lost_q    <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    lost_d    = lost_q;
    lost_ev   = ((state_q == RELEASE) || (state_q == RUN)) && !lk_s;
    relock    = lost_ev || (bus.force_relock && (state_q != PLL_RST));

    unique case (state_q)
      PLL_RST: begin
        pll_rst_d = 1'b1;
        if (cnt_q == PRC_LAST) begin
          pll_rst_d = 1'b0;
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      QUALIFY: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          dom_d   = N_DOM'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == REL_LASTC) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // Thermometer release: domain k opens once the count reaches k*STAGGER.
          for (int unsigned k = 0; k < N_DOM; k++) begin
            dom_d[k] = (32'(cnt_d) >= k * STAGGER_CYCLES);
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d   = PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        dom_d     = '0;
        ready_d   = 1'b0;
      end
    endcase

    // Loss of lock / relock request overrides normal progress; loss takes the count.
    if (relock) begin
      state_d   = PLL_RST;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      dom_d     = '0;
      ready_d   = 1'b0;
      if (lost_ev && (lost_q != '1)) begin
        lost_d = lost_q + CNT_W'(1);
      end
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q;
  assign bus.ready        = ready_q;
  assign bus.lost_cnt     = lost_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed plan steps plus a
// randomized lock/relock phase, checked against a phase/age reference model.
module tb_pll_lock_sequencer;

  localparam int unsigned N_DOM = 3;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned PRC   = 4;
  localparam int unsigned QUAL  = 8;
  localparam int unsigned TO    = 32;
  localparam int unsigned STAG  = 2;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  logic locked = 1'b0;
  logic force_r = 1'b0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer_if #(.N_DOM(N_DOM), .CNT_W(8)) bus_a ();
  pll_lock_sequencer_if #(.N_DOM(N_DOM), .CNT_W(2)) bus_b ();

  assign bus_a.pll_locked   = locked;
  assign bus_a.force_relock = force_r;
  assign bus_b.pll_locked   = locked;
  assign bus_b.force_relock = force_r;

  pll_lock_sequencer #(
    .N_DOM(N_DOM), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_QUAL_CYCLES(QUAL),
    .LOCK_TIMEOUT(TO), .STAGGER_CYCLES(STAG), .CNT_W(8)
  ) dut_a (.refclk(refclk), .rst_n(rst_n), .bus(bus_a));

  pll_lock_sequencer #(
    .N_DOM(N_DOM), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_QUAL_CYCLES(QUAL),
    .LOCK_TIMEOUT(TO), .STAGGER_CYCLES(STAG), .CNT_W(2)
  ) dut_b (.refclk(refclk), .rst_n(rst_n), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  // Reference model: current phase, edges spent in it, and lock-loss tally.
  int m_phase, m_age, m_lost, edge_n;
  bit hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_dom();
    if (m_phase == 4) return 3'b111;
    if (m_phase == 3) return 3'((1 << (m_age / STAG + 1)) - 1);
    return 3'b000;
  endfunction

  function automatic logic [15:0] exp_vec(input int sat);
    int l;
    l = (m_lost > sat) ? sat : m_lost;
    return {3'(m_phase), (m_phase == 0), m_dom(), (m_phase == 4), 8'(l)};
  endfunction

  function automatic logic [15:0] obs_a();
    return {bus_a.state, bus_a.pll_rst, bus_a.domain_rst_n, bus_a.ready, bus_a.lost_cnt};
  endfunction

  function automatic logic [15:0] obs_b();
    return {bus_b.state, bus_b.pll_rst, bus_b.domain_rst_n, bus_b.ready, 6'b0, bus_b.lost_cnt};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_lost  = 0;
    hist.delete();
  endtask

  task automatic go(input int ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  task automatic model_step();
    bit lk, lost_ev, frc;
    lk = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
    hist.push_back(locked);
    if (hist.size() > 8) void'(hist.pop_front());
    lost_ev = (m_phase >= 3) && !lk;
    frc     = force_r && (m_phase != 0);
    if (lost_ev || frc) begin
      if (lost_ev) m_lost++;
      go(0);
    end else begin
      case (m_phase)
        0: if (m_age == PRC - 1) go(1); else m_age++;
        1: if (lk) go(2); else if (m_age == TO - 1) go(0); else m_age++;
        2: if (!lk) go(1); else if (m_age == QUAL - 1) go(3); else m_age++;
        3: if (m_age == (N_DOM - 1) * STAG) go(4); else m_age++;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("outs_a", 32'(obs_a()), 32'(exp_vec(255)));
    chk("outs_b", 32'(obs_b()), 32'(exp_vec(3)));
  endtask

  task automatic tick();
    @(posedge refclk);
    if (!rst_n) model_reset(); else model_step();
    edge_n++;
    @(negedge refclk);
    compare_all();
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    for (int i = 0; i < budget && m_phase != ph; i++) tick();
    chk(tag, 32'(bus_a.state), 32'(ph));
  endtask

  initial begin
    int low_left;
    model_reset();
    edge_n = 0;

    // Held in reset: everything at reset values.
    repeat (3) tick();
    chk("rst_pll_rst", 32'(bus_a.pll_rst), 32'd1);
    chk("rst_dom", 32'(bus_a.domain_rst_n), 32'd0);

    // Plan 1: lock present throughout.
    locked = 1'b1;
    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      case (edge_n)
        3:  chk("p1_prst_e3", 32'(bus_a.pll_rst), 32'd1);
        4:  begin
              chk("p1_prst_e4", 32'(bus_a.pll_rst), 32'd0);
              chk("p1_wait_e4", 32'(bus_a.state), 32'd1);
            end
        5:  chk("p1_qual_e5", 32'(bus_a.state), 32'd2);
        12: chk("p1_dom_e12", 32'(bus_a.domain_rst_n), 32'b000);
        13: chk("p1_dom_e13", 32'(bus_a.domain_rst_n), 32'b001);
        14: chk("p1_dom_e14", 32'(bus_a.domain_rst_n), 32'b001);
        15: chk("p1_dom_e15", 32'(bus_a.domain_rst_n), 32'b011);
        17: begin
              chk("p1_dom_e17", 32'(bus_a.domain_rst_n), 32'b111);
              chk("p1_rdy_e17", 32'(bus_a.ready), 32'd0);
            end
        18: begin
              chk("p1_rdy_e18", 32'(bus_a.ready), 32'd1);
              chk("p1_run_e18", 32'(bus_a.state), 32'd4);
              chk("p1_lost_e18", 32'(bus_a.lost_cnt), 32'd0);
            end
        default: ;
      endcase
    end
    repeat (5) tick();

    // Plan 3: one-cycle lock drop in RUN.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    chk("p3_dom", 32'(bus_a.domain_rst_n), 32'd0);
    chk("p3_rdy", 32'(bus_a.ready), 32'd0);
    chk("p3_prst", 32'(bus_a.pll_rst), 32'd1);
    chk("p3_lost", 32'(bus_a.lost_cnt), 32'd1);
    wait_phase(4, 100, "p3_rerun");
    chk("p3_ready", 32'(bus_a.ready), 32'd1);

    // Plan 5: force_relock in RUN, then an ignored pulse during PLL_RST.
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    chk("p5_prst", 32'(bus_a.pll_rst), 32'd1);
    chk("p5_dom", 32'(bus_a.domain_rst_n), 32'd0);
    chk("p5_lost", 32'(bus_a.lost_cnt), 32'd1);
    tick();
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    tick();
    chk("p5_prst_hold", 32'(bus_a.pll_rst), 32'd1);
    tick();
    chk("p5_prst_fall", 32'(bus_a.pll_rst), 32'd0);

    // Plan 4: glitch seen by QUALIFY with counter at 5.
    wait_phase(2, 20, "p4_qual");
    for (int i = 0; i < 20 && m_age != 3; i++) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    chk("p4_back_wait", 32'(bus_a.state), 32'd1);
    chk("p4_lost", 32'(bus_a.lost_cnt), 32'd1);
    tick();
    chk("p4_requal", 32'(bus_a.state), 32'd2);
    repeat (7) tick();
    chk("p4_requal_7", 32'(bus_a.state), 32'd2);
    tick();
    chk("p4_release", 32'(bus_a.state), 32'd3);

    // Plan 6a: asynchronous reset mid-RELEASE.
    tick();
    tick();
    chk("p6_dom011", 32'(bus_a.domain_rst_n), 32'b011);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("p6_async_dom", 32'(bus_a.domain_rst_n), 32'd0);
    chk("p6_async_prst", 32'(bus_a.pll_rst), 32'd1);
    tick();
    tick();

    // Plan 2: no lock ever; periodic PLL reset retries.
    locked = 1'b0;
    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      case (edge_n)
        4:  chk("p2_fall_e4", 32'(bus_a.pll_rst), 32'd0);
        35: chk("p2_low_e35", 32'(bus_a.pll_rst), 32'd0);
        36: chk("p2_rise_e36", 32'(bus_a.pll_rst), 32'd1);
        40: chk("p2_fall_e40", 32'(bus_a.pll_rst), 32'd0);
        72: chk("p2_rise_e72", 32'(bus_a.pll_rst), 32'd1);
        default: ;
      endcase
    end
    chk("p2_dom", 32'(bus_a.domain_rst_n), 32'd0);
    chk("p2_lost", 32'(bus_a.lost_cnt), 32'd0);

    // Plan 6b: five losses; the last coincides with a force_relock.
    locked = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_phase(4, 120, "p6_run");
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      if (k == 4) force_r = 1'b1;
      tick();
      force_r = 1'b0;
    end
    chk("p6_lost_a", 32'(bus_a.lost_cnt), 32'd5);
    chk("p6_lost_sat", 32'(bus_b.lost_cnt), 32'd3);

    // Randomized lock drops, long outages and relock requests.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        locked = 1'b0;
        low_left--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 99) < 3) low_left = int'($urandom_range(1, 45));
      end
      force_r = ($urandom_range(0, 99) < 2);
      tick();
    end
    force_r = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
